// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer feeding CP0: qualifies EX-stage traps, pulses CP0, then redirects and flushes.
// Optional external interrupt support is enabled with `define EXC_IRQ_EN.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter logic [4:0]  CAUSE_SYSCALL = 5'd8,
    parameter logic [4:0]  CAUSE_BREAK   = 5'd9,
    parameter logic [4:0]  CAUSE_TEQ     = 5'd13,
    parameter logic [4:0]  CAUSE_INT     = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        teq_cond,
    input  logic        req_eret,
    input  logic [31:0] req_pc,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
`ifdef EXC_IRQ_EN
    input  logic        irq,
`endif
    output logic        exception,
    output logic        eret,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_REDIRECT,
        S_DRAIN
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        exception_q;
    logic        eret_q;
    logic [4:0]  cause_q;
    logic [31:0] epc_q;
    logic        stall_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        take_eret;
    logic        take_teq;
    logic        take_break;
    logic        take_sys;
    logic        take_sync;
    logic        take_trap;
    logic        take_irq;
    logic [4:0]  cause_d;

    logic        unused_status;
    assign unused_status = ^status[31:4];

`ifdef EXC_IRQ_EN
    logic       irq_s1_q;
    logic       irq_s2_q;
    logic       irq_prev_q;
    logic       irq_pending_q;
    logic       irq_rise;
    logic       irq_hit;

    assign irq_rise = irq_s2_q & ~irq_prev_q;
    // A rising edge seen this cycle is eligible immediately, without waiting for pending to register.
    assign irq_hit  = irq_pending_q | irq_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1_q      <= 1'b0;
            irq_s2_q      <= 1'b0;
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_s1_q      <= irq;
            irq_s2_q      <= irq_s1_q;
            irq_prev_q    <= irq_s2_q;
            irq_pending_q <= irq_hit & ~take_irq;
        end
    end
`endif

    always_comb begin
        take_eret  = req_valid & req_eret;
        take_teq   = req_valid & req_teq & teq_cond & status[0] & status[3];
        take_break = req_valid & req_break & status[0] & status[2];
        take_sys   = req_valid & req_syscall & status[0] & status[1];
        take_sync  = take_eret | take_teq | take_break | take_sys;
        take_irq   = 1'b0;
`ifdef EXC_IRQ_EN
        take_irq   = (state_q == S_IDLE) & req_valid & ~take_sync & status[0] & irq_hit;
`endif
        take_trap  = ~take_eret & (take_teq | take_break | take_sys | take_irq);
        if (take_teq) begin
            cause_d = CAUSE_TEQ;
        end else if (take_break) begin
            cause_d = CAUSE_BREAK;
        end else if (take_sys) begin
            cause_d = CAUSE_SYSCALL;
        end else begin
            cause_d = CAUSE_INT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            exception_q      <= 1'b0;
            eret_q           <= 1'b0;
            cause_q          <= '0;
            epc_q            <= '0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    exception_q      <= 1'b0;
                    eret_q           <= 1'b0;
                    stall_q          <= 1'b0;
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    if (take_eret) begin
                        eret_q  <= 1'b1;
                        stall_q <= 1'b1;
                        flush_q <= 1'b1;
                        state_q <= S_COMMIT;
                    end else if (take_trap) begin
                        exception_q <= 1'b1;
                        cause_q     <= cause_d;
                        epc_q       <= req_pc;
                        stall_q     <= 1'b1;
                        flush_q     <= 1'b1;
                        state_q     <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // CP0 presents EPC or handler address on exc_addr while eret/exception is high.
                    exception_q      <= 1'b0;
                    eret_q           <= 1'b0;
                    stall_q          <= 1'b0;
                    flush_q          <= 1'b1;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= exc_addr;
                    state_q          <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    cnt_q            <= 4'(FLUSH_CYCLES - 1);
                    if (FLUSH_CYCLES > 1) begin
                        flush_q <= 1'b1;
                        state_q <= S_DRAIN;
                    end else begin
                        flush_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        flush_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign exception      = exception_q;
    assign eret           = eret_q;
    assign cause          = cause_q;
    assign epc            = epc_q;
    assign stall          = stall_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with FLUSH_CYCLES=2; interrupt cases build only with EXC_IRQ_EN.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_syscall, req_break, req_teq, teq_cond, req_eret;
    logic [31:0] req_pc, status, exc_addr;
    logic        exception, eret, stall, flush, redirect_valid;
    logic [4:0]  cause;
    logic [31:0] epc, redirect_pc;
`ifdef EXC_IRQ_EN
    logic        irq;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pulses;

    always #5 clk = ~clk;

    exc_ctrl #(
        .FLUSH_CYCLES (2),
        .CAUSE_SYSCALL(5'd8),
        .CAUSE_BREAK  (5'd9),
        .CAUSE_TEQ    (5'd13),
        .CAUSE_INT    (5'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_syscall   (req_syscall),
        .req_break     (req_break),
        .req_teq       (req_teq),
        .teq_cond      (teq_cond),
        .req_eret      (req_eret),
        .req_pc        (req_pc),
        .status        (status),
        .exc_addr      (exc_addr),
`ifdef EXC_IRQ_EN
        .irq           (irq),
`endif
        .exception     (exception),
        .eret          (eret),
        .cause         (cause),
        .epc           (epc),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_req();
        req_valid = 0; req_syscall = 0; req_break = 0;
        req_teq = 0; teq_cond = 0; req_eret = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_req();
        req_pc = '0; status = '0; exc_addr = '0;
`ifdef EXC_IRQ_EN
        irq = 1'b0;
`endif
        repeat (2) step();
        chk("rst_exception", exception, 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall", stall, 0);
        chk("rst_redir_pc", redirect_pc, 0);
        chk("rst_epc", epc, 0);
        rst = 1'b0;
        step();

        // T1: syscall
        status = 32'hF; exc_addr = 32'h0040_0004;
        req_valid = 1; req_syscall = 1; req_pc = 32'h0040_0020;
        step(); clear_req();
        chk("t1_exception", exception, 1);
        chk("t1_eret", eret, 0);
        chk("t1_cause", cause, 8);
        chk("t1_epc", epc, 32'h0040_0020);
        chk("t1_flush", flush, 1);
        chk("t1_stall", stall, 1);
        chk("t1_rv_commit", redirect_valid, 0);
        step();
        chk("t1_rv", redirect_valid, 1);
        chk("t1_rpc", redirect_pc, 32'h0040_0004);
        chk("t1_exc_off", exception, 0);
        chk("t1_stall_off", stall, 0);
        step();
        chk("t1_drain_flush", flush, 1);
        chk("t1_drain_rv", redirect_valid, 0);
        step();
        chk("t1_idle_flush", flush, 0);

        // T2: masked requests, then enabled break
        status = 32'hB; req_valid = 1; req_break = 1;
        step(); clear_req();
        chk("t2_brk_masked_exc", exception, 0);
        chk("t2_brk_masked_flush", flush, 0);
        status = 32'hF; req_valid = 1; req_teq = 1; teq_cond = 0;
        step(); clear_req();
        chk("t2_teq_false_exc", exception, 0);
        chk("t2_teq_false_flush", flush, 0);
        status = 32'hE; req_valid = 1; req_syscall = 1;
        step(); clear_req();
        chk("t2_ie_off_exc", exception, 0);
        status = 32'hF; req_valid = 1; req_break = 1; req_pc = 32'h0040_0030;
        step(); clear_req();
        chk("t2_brk_exc", exception, 1);
        chk("t2_brk_cause", cause, 9);
        chk("t2_brk_epc", epc, 32'h0040_0030);
        repeat (3) step();

        // T3: ERET leaves cause/epc intact
        exc_addr = 32'h0040_0024;
        req_valid = 1; req_eret = 1; req_pc = 32'h0040_0100;
        step(); clear_req();
        chk("t3_eret", eret, 1);
        chk("t3_exc", exception, 0);
        chk("t3_cause", cause, 9);
        chk("t3_epc", epc, 32'h0040_0030);
        step();
        chk("t3_eret_off", eret, 0);
        chk("t3_rv", redirect_valid, 1);
        chk("t3_rpc", redirect_pc, 32'h0040_0024);
        repeat (2) step();

        // T4: requests during sequence ignored; flush length
        exc_addr = 32'h0040_0004;
        pulses = 0;
        req_valid = 1; req_syscall = 1; req_pc = 32'h0040_0200;
        step();
        req_syscall = 0; req_teq = 1; teq_cond = 1;
        pulses += exception;
        chk("t4_flush_c", flush, 1);
        chk("t4_cause_c", cause, 8);
        step();
        pulses += exception;
        chk("t4_flush_r", flush, 1);
        step();
        pulses += exception;
        chk("t4_flush_d", flush, 1);
        clear_req();
        step();
        pulses += exception;
        chk("t4_flush_idle", flush, 0);
        chk("t4_pulses", pulses, 1);
        chk("t4_epc", epc, 32'h0040_0200);
        // TEQ taken with cause 13
        req_valid = 1; req_teq = 1; teq_cond = 1; req_pc = 32'h0040_0210;
        step(); clear_req();
        chk("t4_teq_cause", cause, 13);
        repeat (3) step();

        // T5: asynchronous reset during DRAIN
        req_valid = 1; req_syscall = 1; req_pc = 32'h0040_0300;
        step(); clear_req();
        repeat (2) step();
        chk("t5_pre_flush", flush, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_flush", flush, 0);
        chk("t5_rst_epc", epc, 0);
        chk("t5_rst_cause", cause, 0);
        chk("t5_rst_rpc", redirect_pc, 0);
        step(); rst = 1'b0;
        step();
        req_valid = 1; req_syscall = 1; req_pc = 32'h0040_0400;
        step(); clear_req();
        chk("t5_again_exc", exception, 1);
        chk("t5_again_epc", epc, 32'h0040_0400);
        repeat (3) step();
        chk("t5_again_idle", flush, 0);

`ifdef EXC_IRQ_EN
        // T6: interrupt taken, then held while masked
        status = 32'hF; req_valid = 1; req_pc = 32'h0040_0040;
        irq = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (exception) begin
                pulses++;
                chk("t6_cause", cause, 0);
                chk("t6_epc", epc, 32'h0040_0040);
                clear_req();
            end
        end
        chk("t6_taken", pulses, 1);
        clear_req(); irq = 1'b0;
        repeat (4) step();
        status = 32'h0; req_valid = 1; req_pc = 32'h0040_0050; irq = 1'b1;
        pulses = 0;
        repeat (5) begin
            step();
            pulses += exception;
        end
        chk("t6_masked", pulses, 0);
        status = 32'h1;
        step(); clear_req();
        chk("t6_pending_exc", exception, 1);
        chk("t6_pending_epc", epc, 32'h0040_0050);
        repeat (4) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
